// File: rtl/hartslag_pkg.sv
// Shared types and helpers for the heartbeat stimulus transmitter.
package hartslag_pkg;

  // Default width of the rate and beat-count buses.
  localparam int RATE_W_DEFAULT = 8;

  // Transmitter operating states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Highest beat count per window that still leaves at least pulse_w low
  // cycles between consecutive pulses.
  function automatic int max_rate(input int window_cycles, input int pulse_w);
    return window_cycles / (2 * pulse_w);
  endfunction

endpackage

// File: rtl/hartslag_oneshot.sv
// Fixed-width pulse generator: a start strobe yields PULSE_W high cycles,
// beginning one cycle after the strobe. Strobes while busy are ignored.
module hartslag_oneshot #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic pulse_out,
  output logic busy
);

  localparam int CW = (PULSE_W < 1) ? 1 : $clog2(PULSE_W + 1);

  logic [CW-1:0] remaining;

  // Remaining high cycles: load on an accepted start, count down to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (reset) begin
      remaining <= '0;
    end else if (start && (remaining == '0)) begin
      remaining <= CW'(PULSE_W);
    end else if (remaining != '0) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign pulse_out = (remaining != '0);
  assign busy      = pulse_out;

endmodule

// File: rtl/hartslag_gen.sv
// Heartbeat stimulus transmitter: N evenly spaced pulses per measurement
// window plus a one-cycle window tick on the last cycle of each window.
module hartslag_gen
  import hartslag_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int PULSE_W       = 4,
  parameter int RATE_W        = RATE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_in,
  input  logic              rate_load,
  output logic              pulse_out,
  output logic              window_tick,
  output logic [RATE_W-1:0] beats_sent,
  output logic              rate_clamped,
  output logic              active
);

  localparam int MAX_RATE = max_rate(WINDOW_CYCLES, PULSE_W);
  localparam int CNT_W    = $clog2(WINDOW_CYCLES + 1);
  localparam int SUM_W    = CNT_W + 1;

  localparam logic [RATE_W-1:0] MAX_RATE_V = RATE_W'(MAX_RATE);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [SUM_W-1:0]  WIN_SUM    = SUM_W'(WINDOW_CYCLES);

  state_t             state;
  state_t             state_next;
  logic [RATE_W-1:0]  shadow_rate;
  logic [RATE_W-1:0]  active_rate;
  logic [RATE_W-1:0]  eff_rate;
  logic [CNT_W-1:0]   acc;
  logic [CNT_W-1:0]   acc_next;
  logic [CNT_W-1:0]   win_cnt;
  logic [SUM_W-1:0]   sum;
  logic [RATE_W-1:0]  win_beats;
  logic               pulse_start;
  logic               last_cycle;
  logic               pulse_busy;

  // Rate accumulator and window decode; starts only happen in RUN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    eff_rate    = shadow_rate;
    sum         = {1'b0, acc} + SUM_W'(active_rate);
    acc_next    = acc;
    pulse_start = 1'b0;
    last_cycle  = 1'b0;
    if (shadow_rate > MAX_RATE_V) begin
      eff_rate = MAX_RATE_V;
    end
    if (state == RUN) begin
      last_cycle = (win_cnt == LAST_IDX);
      if (sum >= WIN_SUM) begin
        pulse_start = 1'b1;
        acc_next    = CNT_W'(sum - WIN_SUM);
      end else begin
        acc_next    = CNT_W'(sum);
      end
    end
  end

  // Next-state logic: DRAIN lets an in-flight pulse finish before IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)      state_next = RUN;
      RUN:     if (!enable)     state_next = DRAIN;
      DRAIN:   if (!pulse_busy) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shadow rate capture, per-window counting and window-boundary updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_rate  <= '0;
      rate_clamped <= 1'b0;
      active_rate  <= '0;
      acc          <= '0;
      win_cnt      <= '0;
      win_beats    <= '0;
      beats_sent   <= '0;
    end else begin
      if (rate_load) begin
        shadow_rate  <= rate_in;
        rate_clamped <= (rate_in > MAX_RATE_V);
      end
      case (state)
        IDLE: begin
          acc         <= '0;
          win_cnt     <= '0;
          win_beats   <= '0;
          active_rate <= eff_rate;
        end
        RUN: begin
          if (last_cycle) begin
            // A start on this same last cycle still belongs to this window.
            beats_sent  <= win_beats + RATE_W'(pulse_start);
            acc         <= '0;
            win_cnt     <= '0;
            win_beats   <= '0;
            active_rate <= eff_rate;
          end else begin
            acc       <= acc_next;
            win_cnt   <= win_cnt + CNT_W'(1);
            win_beats <= win_beats + RATE_W'(pulse_start);
          end
        end
        default: begin
          // DRAIN holds the window state until IDLE clears it.
        end
      endcase
    end
  end

  hartslag_oneshot #(
    .PULSE_W (PULSE_W)
  ) u_oneshot (
    .clk       (clk),
    .reset     (reset),
    .start     (pulse_start),
    .pulse_out (pulse_out),
    .busy      (pulse_busy)
  );

  assign window_tick = last_cycle;
  assign active      = (state != IDLE);

endmodule

// File: tb/tb_hartslag_gen.sv
// Self-checking bench for hartslag_gen with a cycle-level reference model.
module tb_hartslag_gen;

  localparam int W    = 100;
  localparam int PW   = 4;
  localparam int MAXR = 12;
  localparam int RW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [RW-1:0] rate_in;
  logic          rate_load;
  logic          pulse_out;
  logic          window_tick;
  logic [RW-1:0] beats_sent;
  logic          rate_clamped;
  logic          active;

  int n_checks = 0;
  int n_errors = 0;

  hartslag_gen #(
    .WINDOW_CYCLES (W),
    .PULSE_W       (PW),
    .RATE_W        (RW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rate_in      (rate_in),
    .rate_load    (rate_load),
    .pulse_out    (pulse_out),
    .window_tick  (window_tick),
    .beats_sent   (beats_sent),
    .rate_clamped (rate_clamped),
    .active       (active)
  );

  initial forever #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 drain. Pulse starts use the
  // closed form "beat k starts where floor((i+1)*N/W) steps up".
  int m_mode, m_idx, m_n, m_cnt, m_beats, m_rem, m_shadow;

  function automatic bit m_start();
    return (m_mode == 1) && ((((m_idx + 1) * m_n) / W) != ((m_idx * m_n) / W));
  endfunction

  function automatic bit m_tick();
    return (m_mode == 1) && (m_idx == W - 1);
  endfunction

  task automatic model_edge();
    bit st, tk, pl;
    int eff;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_n = 0; m_cnt = 0;
      m_beats = 0; m_rem = 0; m_shadow = 0;
    end else begin
      st  = m_start();
      tk  = m_tick();
      pl  = (m_rem > 0);
      eff = (m_shadow > MAXR) ? MAXR : m_shadow;
      case (m_mode)
        0: begin
          m_n = eff; m_idx = 0; m_cnt = 0;
          if (enable) m_mode = 1;
        end
        1: begin
          if (tk) begin
            m_beats = m_cnt + int'(st); m_cnt = 0; m_idx = 0; m_n = eff;
          end else begin
            m_idx++; m_cnt += int'(st);
          end
          if (!enable) m_mode = 2;
        end
        default: if (!pl) m_mode = 0;
      endcase
      if (m_rem == 0 && st) m_rem = PW;
      else if (m_rem > 0) m_rem--;
      if (rate_load) m_shadow = int'(rate_in);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("pulse_out",    int'(pulse_out),    int'(m_rem > 0));
    check("window_tick",  int'(window_tick),  int'(m_tick()));
    check("beats_sent",   int'(beats_sent),   m_beats);
    check("rate_clamped", int'(rate_clamped), int'(m_shadow > MAXR));
    check("active",       int'(active),       int'(m_mode != 0));
  endtask

  // One clock: model advances with the DUT, outputs compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; rate_load = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic load_rate(input int r);
    rate_in = RW'(r); rate_load = 1'b1;
    step();
    rate_load = 1'b0;
  endtask

  task automatic wait_tick(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (window_tick) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_rise(input int budget, input string name);
    bit ok = 1'b0;
    bit prev = pulse_out;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (pulse_out && !prev) ok = 1'b1;
      prev = pulse_out;
    end
    check(name, int'(ok), 1);
  endtask

  typedef struct {
    int rate;
    int beats;
    int clamped;
    int gap;   // minimum low run between pulses; 1000 when no pulses
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset = 1'b1; enable = 1'b0; rate_in = '0; rate_load = 1'b0;
    m_mode = 0; m_idx = 0; m_n = 0; m_cnt = 0; m_beats = 0; m_rem = 0; m_shadow = 0;

    vecs[0] = '{4,   4,  0, 21};
    vecs[1] = '{30,  12, 1, 4};
    vecs[2] = '{7,   7,  0, 10};
    vecs[3] = '{9,   9,  0, 7};     // loop-back rate: 9 beats each window
    vecs[4] = '{12,  12, 0, 4};
    vecs[5] = '{13,  12, 1, 4};
    vecs[6] = '{1,   1,  0, 96};
    vecs[7] = '{0,   0,  0, 1000};
    vecs[8] = '{255, 12, 1, 4};
    vecs[9] = '{2,   2,  0, 46};

    // Reset state.
    step();
    check("reset_pulse", int'(pulse_out), 0);
    check("reset_active", int'(active), 0);
    check("reset_beats", int'(beats_sent), 0);
    step();
    reset = 1'b0;

    // Table: two full windows per rate, measured after the first tick.
    for (int v = 0; v < 10; v++) begin
      int rises, ticks, low_run, high_run, min_gap;
      bit prev, seen;
      do_reset();
      load_rate(vecs[v].rate);
      enable = 1'b1;
      wait_tick(300, "first_tick");
      rises = 0; ticks = 0; low_run = 0; high_run = 0; min_gap = 1000;
      prev = pulse_out; seen = 1'b0;
      for (int c = 0; c < 2 * W; c++) begin
        step();
        if (window_tick) ticks++;
        if (pulse_out) begin
          if (!prev) begin
            rises++;
            if (seen && low_run < min_gap) min_gap = low_run;
            seen = 1'b1;
          end
          high_run++;
          low_run = 0;
        end else begin
          if (prev) check("pulse_width", high_run, PW);
          high_run = 0;
          low_run++;
        end
        prev = pulse_out;
      end
      check($sformatf("beats_r%0d", vecs[v].rate), int'(beats_sent), vecs[v].beats);
      check($sformatf("clamp_r%0d", vecs[v].rate), int'(rate_clamped), vecs[v].clamped);
      check($sformatf("rises_r%0d", vecs[v].rate), rises, 2 * vecs[v].beats);
      check($sformatf("ticks_r%0d", vecs[v].rate), ticks, 2);
      check($sformatf("gap_r%0d", vecs[v].rate), min_gap, vecs[v].gap);
      enable = 1'b0;
      for (int c = 0; c < 8; c++) step();
    end

    // Mid-window rate change 4 -> 7 applies from the next window on.
    do_reset();
    load_rate(4);
    enable = 1'b1;
    for (int c = 0; c < 50; c++) step();
    load_rate(7);
    wait_tick(100, "mid_tick0");
    step();
    check("mid_beats_first", int'(beats_sent), 4);
    wait_tick(150, "mid_tick1");
    step();
    check("mid_beats_second", int'(beats_sent), 7);

    // Drop enable one cycle after a start: pulse completes, then IDLE.
    do_reset();
    load_rate(4);
    enable = 1'b1;
    wait_rise(200, "drain_rise");
    enable = 1'b0;
    begin
      int highs = 1;
      int ticks = 0;
      bit fell = 1'b0;
      for (int c = 0; c < 10 && !fell; c++) begin
        step();
        if (pulse_out) highs++;
        else fell = 1'b1;
      end
      check("drain_fell", int'(fell), 1);
      check("drain_width", highs, PW);
      check("drain_active_hold", int'(active), 1);
      step();
      check("drain_active_drop", int'(active), 0);
      for (int c = 0; c < 150; c++) begin
        step();
        if (window_tick) ticks++;
      end
      check("drain_no_tick", ticks, 0);
    end

    // Reset while pulse_out is high at window index 50.
    do_reset();
    load_rate(4);
    enable = 1'b1;
    wait_rise(200, "rst_rise1");
    wait_rise(200, "rst_rise2");
    check("rst_pulse_high", int'(pulse_out), 1);
    reset = 1'b1;
    step();
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_tick", int'(window_tick), 0);
    check("rst_beats", int'(beats_sent), 0);
    check("rst_clamp", int'(rate_clamped), 0);
    check("rst_active", int'(active), 0);
    reset = 1'b0;
    enable = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      rate_load = ($urandom_range(0, 39) == 0);
      rate_in   = RW'($urandom_range(0, 20));
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      reset     = ($urandom_range(0, 1999) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
